// File: rtl/data_mem_master.sv
// data_mem_master: MEM-stage initiator for the data-memory port.
// Takes one load/store at a time over valid/ready, drives registered
// memory strobes, and returns a single-cycle response tagged with rd.
module data_mem_master #(
  parameter int MEM_WORDS = 16,
  parameter int READ_WAIT = 1
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic        resp_write,
  output logic        resp_err,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] address,
  output logic [31:0] writeData,
  input  logic [31:0] readData
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS);
  localparam logic [3:0]  WAIT_INIT  = 4'(READ_WAIT - 1);

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic [4:0]  rd_tag, rd_tag_nxt;
  logic        req_ready_nxt, mem_read_nxt, mem_write_nxt;
  logic        resp_valid_nxt, resp_write_nxt, resp_err_nxt;
  logic [31:0] resp_data_nxt, address_nxt, write_data_nxt;
  logic [4:0]  resp_rd_nxt;

  // State register; reset returns to IDLE immediately.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    rd_tag_nxt     = rd_tag;
    req_ready_nxt  = 1'b0;
    mem_read_nxt   = 1'b0;
    mem_write_nxt  = 1'b0;
    resp_valid_nxt = 1'b0;
    resp_write_nxt = resp_write;
    resp_err_nxt   = resp_err;
    resp_data_nxt  = resp_data;
    resp_rd_nxt    = resp_rd;
    address_nxt    = address;
    write_data_nxt = writeData;
    case (state)
      IDLE: begin
        req_ready_nxt = 1'b1;
        if (req_valid) begin
          req_ready_nxt = 1'b0;
          rd_tag_nxt    = req_rd;
          if (req_addr >= ADDR_LIMIT) begin
            // Out-of-range: answer at once, leave memory lines untouched.
            state_nxt      = RESP;
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b1;
            resp_write_nxt = req_write;
            resp_data_nxt  = 32'd0;
            resp_rd_nxt    = req_rd;
          end else if (req_write) begin
            state_nxt      = WRITE;
            mem_write_nxt  = 1'b1;
            address_nxt    = req_addr;
            write_data_nxt = req_wdata;
          end else begin
            state_nxt    = READ;
            mem_read_nxt = 1'b1;
            address_nxt  = req_addr;
            wait_cnt_nxt = WAIT_INIT;
          end
        end
      end
      WRITE: begin
        state_nxt      = RESP;
        resp_valid_nxt = 1'b1;
        resp_write_nxt = 1'b1;
        resp_err_nxt   = 1'b0;
        resp_data_nxt  = 32'd0;
        resp_rd_nxt    = rd_tag;
      end
      READ: begin
        if (memRead) begin
          // Strobe phase: hold memRead for READ_WAIT cycles, address stable.
          if (wait_cnt != 4'd0) begin
            mem_read_nxt = 1'b1;
            wait_cnt_nxt = wait_cnt - 4'd1;
          end
        end else begin
          // Strobe released one cycle ago; address still held, capture data.
          state_nxt      = RESP;
          resp_valid_nxt = 1'b1;
          resp_write_nxt = 1'b0;
          resp_err_nxt   = 1'b0;
          resp_data_nxt  = readData;
          resp_rd_nxt    = rd_tag;
        end
      end
      RESP: begin
        state_nxt     = IDLE;
        req_ready_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output and datapath registers; all cleared by reset so outputs read 0.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      wait_cnt   <= 4'd0;
      rd_tag     <= 5'd0;
      req_ready  <= 1'b0;
      memRead    <= 1'b0;
      memWrite   <= 1'b0;
      resp_valid <= 1'b0;
      resp_write <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= 32'd0;
      resp_rd    <= 5'd0;
      address    <= 32'd0;
      writeData  <= 32'd0;
    end else begin
      wait_cnt   <= wait_cnt_nxt;
      rd_tag     <= rd_tag_nxt;
      req_ready  <= req_ready_nxt;
      memRead    <= mem_read_nxt;
      memWrite   <= mem_write_nxt;
      resp_valid <= resp_valid_nxt;
      resp_write <= resp_write_nxt;
      resp_err   <= resp_err_nxt;
      resp_data  <= resp_data_nxt;
      resp_rd    <= resp_rd_nxt;
      address    <= address_nxt;
      writeData  <= write_data_nxt;
    end
  end

endmodule
